// File: rtl/seg_mux_driver.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// seg_mux_driver
//   Drives one digit of a 3-digit multiplexed 7-segment display. The digit
//   rotator supplies a one-hot strobe; every strobe change forces a blank
//   interval (anti-ghosting) before the newly selected digit is driven.
//   Display data is double-buffered: loads land in a pending buffer and are
//   committed to the active buffer only at frame start (strobe -> 3'b001).
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   : suppress segments of leading-zero digits 2 and 1
//     undefined : all digits shown, including leading zeros
//
// Parameters
//   BLANK_CYC   blank length in clocks (0..255, 0 = a single blank cycle)
// Ports
//   i_clk       clock, rising edge
//   rst_n       asynchronous active-low reset
//   i_digit_en  one-hot digit strobe from the rotator
//   i_bcd       three BCD digits, [3:0] = digit 0
//   i_dp        decimal point per digit
//   i_load      one-cycle strobe capturing i_bcd/i_dp into pending
//   o_seg       segments a..g, [0] = a, active-high
//   o_dp        decimal point, active-high
//   o_digit_en  registered digit enable (one-hot or zero)
//   o_load_ack  one-cycle pulse when pending data is committed
// ----------------------------------------------------------------------------
module seg_mux_driver #(
    parameter logic [7:0] BLANK_CYC = 8'd4
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic [2:0]  i_digit_en,
    input  logic [11:0] i_bcd,
    input  logic [2:0]  i_dp,
    input  logic        i_load,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [2:0]  o_digit_en,
    output logic        o_load_ack
);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  en_q;
    logic [11:0] pend_bcd_q, act_bcd_q;
    logic [2:0]  pend_dp_q, act_dp_q;
    logic        pend_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic [2:0]  dig_q;
    logic        ack_q;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h40;   // non-BCD shows a dash
        endcase
    endfunction

    logic       chg, commit;
    logic       lz_d2, lz_d1;
    logic [3:0] nib;
    logic       dp_sel, onehot, lz_blank;
    logic [6:0] seg_d;
    logic       dp_d;
    logic [2:0] dig_d;

    assign chg    = (i_digit_en != en_q);
    // Frame start is the sampled transition to digit 0.
    assign commit = chg && (i_digit_en == 3'b001) && pend_q;

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_d2 = (act_bcd_q[11:8] == 4'h0);
    assign lz_d1 = lz_d2 && (act_bcd_q[7:4] == 4'h0);
`else
    assign lz_d2 = 1'b0;
    assign lz_d1 = 1'b0;
`endif

    // Drive-phase output values for the digit currently held in en_q.
    always_comb begin
        nib      = 4'h0;
        dp_sel   = 1'b0;
        onehot   = 1'b1;
        lz_blank = 1'b0;
        case (en_q)
            3'b001: begin nib = act_bcd_q[3:0];  dp_sel = act_dp_q[0]; end
            3'b010: begin nib = act_bcd_q[7:4];  dp_sel = act_dp_q[1]; lz_blank = lz_d1; end
            3'b100: begin nib = act_bcd_q[11:8]; dp_sel = act_dp_q[2]; lz_blank = lz_d2; end
            default: onehot = 1'b0;
        endcase
        seg_d = (onehot && !lz_blank) ? dec7(nib) : 7'h00;
        dp_d  = onehot & dp_sel;
        dig_d = onehot ? en_q : 3'b000;
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            cnt_q      <= 8'd0;
            en_q       <= 3'b000;
            pend_bcd_q <= 12'h000;
            pend_dp_q  <= 3'b000;
            pend_q     <= 1'b0;
            act_bcd_q  <= 12'h000;
            act_dp_q   <= 3'b000;
            seg_q      <= 7'h00;
            dp_q       <= 1'b0;
            dig_q      <= 3'b000;
            ack_q      <= 1'b0;
        end else begin
            en_q  <= i_digit_en;
            ack_q <= commit;

            // Commit takes the old pending contents even if a load coincides.
            if (commit) begin
                act_bcd_q <= pend_bcd_q;
                act_dp_q  <= pend_dp_q;
            end
            if (i_load) begin
                pend_bcd_q <= i_bcd;
                pend_dp_q  <= i_dp;
                pend_q     <= 1'b1;
            end else if (commit) begin
                pend_q     <= 1'b0;
            end

            if (chg) begin
                state_q <= ST_BLANK;
                cnt_q   <= BLANK_CYC;
                seg_q   <= 7'h00;
                dp_q    <= 1'b0;
                dig_q   <= 3'b000;
            end else if (state_q == ST_BLANK) begin
                if (cnt_q == 8'd0) begin
                    // Leaving blank: the first driven value lands on this edge.
                    state_q <= ST_DRIVE;
                    seg_q   <= seg_d;
                    dp_q    <= dp_d;
                    dig_q   <= dig_d;
                end else begin
                    cnt_q   <= cnt_q - 8'd1;
                    seg_q   <= 7'h00;
                    dp_q    <= 1'b0;
                    dig_q   <= 3'b000;
                end
            end else begin
                seg_q <= seg_d;
                dp_q  <= dp_d;
                dig_q <= dig_d;
            end
        end
    end

    assign o_seg      = seg_q;
    assign o_dp       = dp_q;
    assign o_digit_en = dig_q;
    assign o_load_ack = ack_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
`timescale 1ns/1ps
module tb_seg_mux_driver;

    localparam int BC   = 4;
    localparam int HOLD = 14;   // 6 edges of blank+first drive, 20 clocks per digit

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  i_digit_en = 3'b000;
    logic [11:0] i_bcd = 12'h000;
    logic [2:0]  i_dp = 3'b000;
    logic        i_load = 1'b0;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [2:0]  o_digit_en;
    logic        o_load_ack;

    always #5 clk = ~clk;

    seg_mux_driver #(.BLANK_CYC(8'd4)) dut (
        .i_clk(clk), .rst_n(rst_n), .i_digit_en(i_digit_en), .i_bcd(i_bcd),
        .i_dp(i_dp), .i_load(i_load), .o_seg(o_seg), .o_dp(o_dp),
        .o_digit_en(o_digit_en), .o_load_ack(o_load_ack)
    );

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  dp;
        logic [6:0]  s0, s1, s2;
    } vec_t;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [2:0] dig;
    } exp_t;

    vec_t vecs[5];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit out_zero();
        return (o_seg === 7'h00) && (o_dp === 1'b0) && (o_digit_en === 3'b000);
    endfunction

    task automatic load(input logic [11:0] b, input logic [2:0] d);
        i_bcd = b; i_dp = d; i_load = 1'b1;
        tick();
        i_load = 1'b0;
    endtask

    // Change already presented: E0 samples it, E1..E4 blank, E5 first drive.
    task automatic blank_then_drive(input string name, input logic exp_ack);
        int   bad;
        exp_t e;
        bad = 0;
        tick();
        i_load = 1'b0;
        chk({name, " ack"}, {31'd0, o_load_ack}, {31'd0, exp_ack});
        if (!out_zero()) bad++;
        for (int k = 0; k < BC; k++) begin
            tick();
            if (!out_zero() || o_load_ack !== 1'b0) bad++;
        end
        chk({name, " blank"}, bad, 0);
        tick();
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: got empty expected entry", name);
        end else begin
            e = sbq.pop_front();
            chk({name, " drive"}, {21'd0, o_seg, o_dp, o_digit_en}, {21'd0, e.seg, e.dp, e.dig});
            bad = 0;
            for (int k = 0; k < HOLD; k++) begin
                tick();
                if ({o_seg, o_dp, o_digit_en} !== {e.seg, e.dp, e.dig}) bad++;
            end
            chk({name, " hold"}, bad, 0);
        end
    endtask

    task automatic step(input string name, input logic [2:0] en, input logic [6:0] seg,
                        input logic dp, input logic exp_ack, input logic ld, input logic [11:0] lb);
        exp_t e;
        e.seg = seg; e.dp = dp; e.dig = en;
        sbq.push_back(e);
        i_digit_en = en;
        if (ld) begin
            i_bcd = lb; i_dp = 3'b000; i_load = 1'b1;
        end
        blank_then_drive(name, exp_ack);
    endtask

    task automatic frame(input string name, input vec_t v, input logic exp_ack);
        step({name, ".d0"}, 3'b001, v.s0, v.dp[0], exp_ack, 1'b0, 12'h000);
        step({name, ".d1"}, 3'b010, v.s1, v.dp[1], 1'b0, 1'b0, 12'h000);
        step({name, ".d2"}, 3'b100, v.s2, v.dp[2], 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        int   bad;
        vec_t v;

        vecs[0] = '{bcd: 12'h395, dp: 3'b010, s0: 7'h6D, s1: 7'h6F, s2: 7'h4F};
        vecs[1] = '{bcd: 12'h876, dp: 3'b101, s0: 7'h7D, s1: 7'h07, s2: 7'h7F};
        vecs[2] = '{bcd: 12'h4AB, dp: 3'b000, s0: 7'h40, s1: 7'h40, s2: 7'h66};
        vecs[3] = '{bcd: 12'h012, dp: 3'b001, s0: 7'h5B, s1: 7'h06, s2: LZ};
        vecs[4] = '{bcd: 12'h007, dp: 3'b100, s0: 7'h07, s1: LZ,    s2: LZ};

        // Reset held with clock running and inputs active.
        bad = 0;
        i_digit_en = 3'b001; i_load = 1'b1; i_bcd = 12'h999;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (!out_zero() || o_load_ack !== 1'b0) bad++;
        end
        chk("reset", bad, 0);
        i_digit_en = 3'b000; i_load = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (!out_zero() || o_load_ack !== 1'b0) bad++;
        end
        chk("idle", bad, 0);

        // Table of display patterns: load, then one full frame commits it.
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].bcd, vecs[i].dp);
            frame($sformatf("v%0d", i), vecs[i], 1'b1);
        end

        // Two loads in one frame, plus a load on the commit edge.
        load(12'h111, 3'b000);
        load(12'h222, 3'b000);
        step("c0", 3'b001, 7'h5B, 1'b0, 1'b1, 1'b1, 12'h333);
        step("c1", 3'b010, 7'h5B, 1'b0, 1'b0, 1'b0, 12'h000);
        step("c2", 3'b100, 7'h5B, 1'b0, 1'b0, 1'b0, 12'h000);
        v = '{bcd: 12'h333, dp: 3'b000, s0: 7'h4F, s1: 7'h4F, s2: 7'h4F};
        frame("p", v, 1'b1);   // pending stayed set -> 333 commits
        frame("n", v, 1'b0);   // nothing pending -> no ack

        // Multi-hot strobe keeps everything dark.
        i_digit_en = 3'b011;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!out_zero() || o_load_ack !== 1'b0) bad++;
        end
        chk("multihot", bad, 0);

        // Reset in the middle of driving aborts at once.
        step("r", 3'b010, 7'h4F, 1'b0, 1'b0, 1'b0, 12'h000);
        rst_n = 1'b0;
        #1;
        chk("rst async", {28'd0, o_seg === 7'h00, o_dp === 1'b0, o_digit_en === 3'b000,
                          o_load_ack === 1'b0}, 32'hF);
        tick();
        tick();
        rst_n = 1'b1;
        // Buffers cleared: digit 1 shows zero (or blank when leading zeros are suppressed).
        sbq.push_back('{seg: LZ, dp: 1'b0, dig: 3'b010});
        blank_then_drive("post", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
